// File: rtl/bpu_update_ctrl_pkg.sv
// Shared types and constants for the BTB write-port controller: counter
// encodings, default index/tag widths, FSM states and queue entry layout.
package bpu_update_ctrl_pkg;

  localparam int unsigned DefIndexW = 5;
  localparam int unsigned DefTagW   = 23;

  // 2-bit direction counter: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] CtrStrongNt = 2'b00;
  localparam logic [1:0] CtrWeakT    = 2'b10;
  localparam logic [1:0] CtrStrongT  = 2'b11;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_t;

  function automatic logic [1:0] satInc(input logic [1:0] ctr);
    return (ctr == CtrStrongT) ? ctr : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] satDec(input logic [1:0] ctr);
    return (ctr == CtrStrongNt) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_update_ctrl_if.sv
// Bundle of the EX/ID update handshakes and the BTB read/write port.
// master = the update controller, slave = the pipeline/BTB side.
interface bpu_update_ctrl_if #(
  parameter int unsigned INDEX_W = bpu_update_ctrl_pkg::DefIndexW,
  parameter int unsigned TAG_W   = bpu_update_ctrl_pkg::DefTagW
) ();

  logic               ex_valid;
  logic               ex_ready;
  logic [31:0]        ex_pc;
  logic [31:0]        ex_target;
  logic               ex_taken;

  logic               id_valid;
  logic               id_ready;
  logic [31:0]        id_pc;
  logic [31:0]        id_target;
  logic               id_taken;

  logic [INDEX_W-1:0] rd_index;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [1:0]         rd_ctr;

  logic               wr_en;
  logic [INDEX_W-1:0] wr_index;
  logic               wr_valid;
  logic [TAG_W-1:0]   wr_tag;
  logic [27:0]        wr_target;
  logic [1:0]         wr_ctr;

  modport master (
    input  ex_valid, ex_pc, ex_target, ex_taken,
    input  id_valid, id_pc, id_target, id_taken,
    input  rd_valid, rd_tag, rd_ctr,
    output ex_ready, id_ready, rd_index,
    output wr_en, wr_index, wr_valid, wr_tag, wr_target, wr_ctr
  );

  modport slave (
    output ex_valid, ex_pc, ex_target, ex_taken,
    output id_valid, id_pc, id_target, id_taken,
    output rd_valid, rd_tag, rd_ctr,
    input  ex_ready, id_ready, rd_index,
    input  wr_en, wr_index, wr_valid, wr_tag, wr_target, wr_ctr
  );

endinterface

// File: rtl/bpu_upd_fifo.sv
// Update queue: dual push (port A lands ahead of port B), single pop,
// synchronous clear and a free-slot count.
module bpu_upd_fifo
  import bpu_update_ctrl_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned PtrW  = $clog2(QDEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            pushA,
  input  upd_t            dataA,
  input  logic            pushB,
  input  upd_t            dataB,
  input  logic            pop,
  output upd_t            head,
  output logic            empty,
  output logic [CntW-1:0] free
);

  upd_t            mem [QDEPTH];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [CntW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushA) mem[wrPtr] <= dataA;
      if (pushB) mem[wrPtr + PtrW'(pushA)] <= dataB;
      wrPtr <= wrPtr + PtrW'(pushA) + PtrW'(pushB);
      if (pop) rdPtr <= rdPtr + PtrW'(1);
      count <= count + CntW'(pushA) + CntW'(pushB) - CntW'(pop);
    end
  end

  assign head  = mem[rdPtr];
  assign empty = (count == '0);
  assign free  = CntW'(QDEPTH) - count;

endmodule

// File: rtl/bpu_update_ctrl.sv
// BTB write-port owner: sweeps the table clear after reset/flush, then applies
// queued EX/ID branch updates with saturating 2-bit counters.
module bpu_update_ctrl
  import bpu_update_ctrl_pkg::*;
#(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned INDEX_W = DefIndexW,
  parameter int unsigned TAG_W   = DefTagW,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_req,
  bpu_update_ctrl_if.master         bus,
  output logic                      pred_enable,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  state_e             state, stateNext;
  logic [INDEX_W-1:0] sweepIdx, sweepNext;
  logic [7:0]         dropNext;

  upd_t               head;
  logic               empty, pop, clear;
  logic [CntW-1:0]    free;
  logic [INDEX_W-1:0] headIdx;
  logic [TAG_W-1:0]   headTag;
  logic               hit;
  logic               unusedBits;

  bpu_upd_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .pushA (bus.ex_valid && bus.ex_ready),
    .dataA ('{pc: bus.ex_pc, target: bus.ex_target, taken: bus.ex_taken}),
    .pushB (bus.id_valid && bus.id_ready),
    .dataB ('{pc: bus.id_pc, target: bus.id_target, taken: bus.id_taken}),
    .pop   (pop),
    .head  (head),
    .empty (empty),
    .free  (free)
  );

  assign headIdx      = head.pc[INDEX_W+3:4];
  assign headTag      = head.pc[31:INDEX_W+4];
  assign bus.rd_index = headIdx;
  assign hit          = bus.rd_valid && (bus.rd_tag == headTag);
  assign unusedBits   = ^{head.pc[3:0], head.target[3:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StInit;
      sweepIdx <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= stateNext;
      sweepIdx <= sweepNext;
      drop_cnt <= dropNext;
    end
  end

  always_comb begin
    stateNext     = state;
    sweepNext     = sweepIdx;
    pop           = 1'b0;
    clear         = 1'b0;
    pred_enable   = 1'b0;
    bus.ex_ready  = 1'b0;
    bus.id_ready  = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_index  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_tag    = '0;
    bus.wr_target = '0;
    bus.wr_ctr    = '0;
    unique case (state)
      StInit, StFlush: begin
        bus.wr_en    = 1'b1;
        bus.wr_index = sweepIdx;
        sweepNext    = sweepIdx + INDEX_W'(1);
        if (sweepIdx == INDEX_W'(ENTRIES - 1)) begin
          stateNext = StRun;
          sweepNext = '0;
        end
      end
      StRun: begin
        pred_enable = 1'b1;
        if (flush_req) begin
          stateNext = StFlush;
          clear     = 1'b1;
        end else begin
          bus.ex_ready = (free >= CntW'(1));
          // ID may take the last slot only when EX is not competing for it.
          bus.id_ready = (free >= CntW'(2)) || ((free >= CntW'(1)) && !bus.ex_valid);
          if (!empty) begin
            pop           = 1'b1;
            bus.wr_index  = headIdx;
            bus.wr_tag    = headTag;
            bus.wr_target = head.target[31:4];
            if (hit) begin
              bus.wr_en    = 1'b1;
              bus.wr_valid = 1'b1;
              bus.wr_ctr   = head.taken ? satInc(bus.rd_ctr) : satDec(bus.rd_ctr);
            end else if (head.taken) begin
              bus.wr_en    = 1'b1;
              bus.wr_valid = 1'b1;
              bus.wr_ctr   = CtrWeakT;
            end
          end
        end
      end
      default: stateNext = StInit;
    endcase
  end

  always_comb begin
    logic [1:0] refused;
    logic [8:0] sum;
    refused  = 2'(bus.ex_valid && !bus.ex_ready) + 2'(bus.id_valid && !bus.id_ready);
    sum      = {1'b0, drop_cnt} + 9'(refused);
    dropNext = sum[8] ? 8'hFF : sum[7:0];
  end

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Directed bench for bpu_update_ctrl: a behavioural BTB answers reads, and a
// scoreboard queue holds the expected RUN-state writes in order.
module tb_bpu_update_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush_req = 1'b0;
  logic       pred_enable;
  logic [7:0] drop_cnt;

  bpu_update_ctrl_if #(.INDEX_W(5), .TAG_W(23)) bus ();

  bpu_update_ctrl #(
    .ENTRIES (32),
    .INDEX_W (5),
    .TAG_W   (23),
    .QDEPTH  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush_req   (flush_req),
    .bus         (bus),
    .pred_enable (pred_enable),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nMis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nMis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural BTB; poke lets the bench force a counter value.
  logic        btbV [32];
  logic [22:0] btbT [32];
  logic [1:0]  btbC [32];
  logic        pokeEn = 1'b0;
  logic [4:0]  pokeIdx = '0;
  logic [1:0]  pokeCtr = '0;

  always @(posedge clk) begin
    if (pokeEn) btbC[pokeIdx] <= pokeCtr;
    if (bus.wr_en === 1'b1) begin
      btbV[bus.wr_index] <= bus.wr_valid;
      btbT[bus.wr_index] <= bus.wr_tag;
      btbC[bus.wr_index] <= bus.wr_ctr;
    end
  end

  assign bus.rd_valid = btbV[bus.rd_index];
  assign bus.rd_tag   = btbT[bus.rd_index];
  assign bus.rd_ctr   = btbC[bus.rd_index];

  typedef struct packed {
    logic [4:0]  idx;
    logic [22:0] tag;
    logic [27:0] tgt;
    logic [1:0]  ctr;
  } exp_t;

  exp_t sbq[$];

  function automatic exp_t mkExp(input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic [1:0] ctr);
    exp_t e;
    e.idx = pc[8:4];
    e.tag = pc[31:9];
    e.tgt = tgt[31:4];
    e.ctr = ctr;
    return e;
  endfunction

  // Every RUN-state write must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && pred_enable === 1'b1 && bus.wr_en === 1'b1) begin
      if (sbq.size() == 0) begin
        nCmp++;
        nMis++;
        $error("FAIL unexpected_write: observed write to index %0d, expected no write",
               bus.wr_index);
      end else begin
        e = sbq.pop_front();
        check("wr_index", 64'(bus.wr_index), 64'(e.idx));
        check("wr_valid", 64'(bus.wr_valid), 64'd1);
        check("wr_tag", 64'(bus.wr_tag), 64'(e.tag));
        check("wr_target", 64'(bus.wr_target), 64'(e.tgt));
        check("wr_ctr", 64'(bus.wr_ctr), 64'(e.ctr));
      end
    end
  end

  task automatic send(input bit isEx, input logic [31:0] pc, input logic [31:0] tgt,
                      input bit taken);
    string tag;
    if (isEx) begin
      bus.ex_valid = 1'b1; bus.ex_pc = pc; bus.ex_target = tgt; bus.ex_taken = taken;
      tag = "ex_ready";
    end else begin
      bus.id_valid = 1'b1; bus.id_pc = pc; bus.id_target = tgt; bus.id_taken = taken;
      tag = "id_ready";
    end
    @(negedge clk);
    check(tag, 64'(isEx ? bus.ex_ready : bus.id_ready), 64'd1);
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    bus.id_valid = 1'b0;
  endtask

  task automatic drain(input int maxCyc, input string tag);
    for (int i = 0; i < maxCyc && sbq.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check(tag, 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [4:0] idx, input logic [1:0] ctr);
    pokeEn = 1'b1; pokeIdx = idx; pokeCtr = ctr;
    @(posedge clk); #1;
    pokeEn = 1'b0;
  endtask

  task automatic sweepCheck(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check(tag, 64'({bus.wr_en, bus.wr_valid, pred_enable, bus.wr_index, bus.wr_tag,
                      bus.wr_target, bus.wr_ctr}),
            64'({1'b1, 1'b0, 1'b0, 5'(i), 23'd0, 28'd0, 2'd0}));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, "_done"}, 64'({pred_enable, bus.wr_en}), 64'(2'b10));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish within 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    logic [31:0] epc, ipc;
    bus.ex_valid = 0; bus.ex_pc = '0; bus.ex_target = '0; bus.ex_taken = 0;
    bus.id_valid = 0; bus.id_pc = '0; bus.id_target = '0; bus.id_taken = 0;

    // Reset-state outputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 64'(bus.wr_en), 64'd1);
    check("rst_wr_index", 64'(bus.wr_index), 64'd0);
    check("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    check("rst_wr_ctr", 64'(bus.wr_ctr), 64'd0);
    check("rst_pred_enable", 64'(pred_enable), 64'd0);
    check("rst_ex_ready", 64'(bus.ex_ready), 64'd0);
    check("rst_id_ready", 64'(bus.id_ready), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sweepCheck("init_sweep");
    nv = 0;
    for (int i = 0; i < 32; i++) if (btbV[i] !== 1'b0) nv++;
    check("btb_cleared", 64'(nv), 64'd0);

    // Miss, EX taken: allocate weakly taken, one-cycle latency.
    sbq.push_back(mkExp(32'h1C00_0040, 32'h1C00_0100, 2'b10));
    send(1, 32'h1C00_0040, 32'h1C00_0100, 1);
    drain(1, "miss_taken_latency");

    // Hit at strong taken stays strong taken; hit at strong NT stays strong NT.
    poke(5'd4, 2'b11);
    sbq.push_back(mkExp(32'h1C00_0040, 32'h1C00_0200, 2'b11));
    send(1, 32'h1C00_0040, 32'h1C00_0200, 1);
    drain(1, "hit_sat_inc");
    poke(5'd4, 2'b00);
    sbq.push_back(mkExp(32'h1C00_0040, 32'h1C00_0300, 2'b00));
    send(1, 32'h1C00_0040, 32'h1C00_0300, 0);
    drain(1, "hit_sat_dec");

    // Back-to-back updates to one index: 00 -> 01 -> 10 -> 01.
    sbq.push_back(mkExp(32'h1C00_0040, 32'h1C00_0400, 2'b01));
    sbq.push_back(mkExp(32'h1C00_0040, 32'h1C00_0500, 2'b10));
    sbq.push_back(mkExp(32'h1C00_0040, 32'h1C00_0600, 2'b01));
    send(1, 32'h1C00_0040, 32'h1C00_0400, 1);
    send(1, 32'h1C00_0040, 32'h1C00_0500, 1);
    send(1, 32'h1C00_0040, 32'h1C00_0600, 0);
    drain(2, "back_to_back");

    // ID path miss taken; EX miss not taken writes nothing; tag mismatch is a miss.
    sbq.push_back(mkExp(32'h1C00_0050, 32'h1C00_0700, 2'b10));
    send(0, 32'h1C00_0050, 32'h1C00_0700, 1);
    drain(1, "id_miss_taken");
    send(1, 32'h1C00_0080, 32'h1C00_0900, 0);
    @(negedge clk);
    check("miss_nt_no_write", 64'(bus.wr_en), 64'd0);
    @(posedge clk); #1;
    sbq.push_back(mkExp(32'h2C00_0040, 32'h2C00_0100, 2'b10));
    send(1, 32'h2C00_0040, 32'h2C00_0100, 1);
    drain(1, "tag_mismatch_alloc");

    // Both sources held for 6 cycles: queue fills, ID refused from cycle 3.
    for (int c = 1; c <= 6; c++) begin
      epc = 32'h4000_0000 | 32'((16 + c) << 4);
      ipc = 32'h4000_0000 | 32'((24 + c) << 4);
      bus.ex_valid = 1; bus.ex_pc = epc; bus.ex_target = epc + 32'h1000; bus.ex_taken = 1;
      bus.id_valid = 1; bus.id_pc = ipc; bus.id_target = ipc + 32'h2000; bus.id_taken = 1;
      sbq.push_back(mkExp(epc, epc + 32'h1000, 2'b10));
      if (c <= 2) sbq.push_back(mkExp(ipc, ipc + 32'h2000, 2'b10));
      @(negedge clk);
      check("stall_ex_ready", 64'(bus.ex_ready), 64'd1);
      check("stall_id_ready", 64'(bus.id_ready), 64'(c <= 2));
      @(posedge clk); #1;
    end
    bus.ex_valid = 0; bus.id_valid = 0;
    drain(8, "stall_drain");
    check("drop_stall", 64'(drop_cnt), 64'd4);

    // Flush with 3 entries queued: only the already-popped head is written.
    bus.ex_valid = 1; bus.ex_pc = 32'h5000_0090; bus.ex_target = 32'h5000_1000; bus.ex_taken = 1;
    bus.id_valid = 1; bus.id_pc = 32'h5000_00A0; bus.id_target = 32'h5000_2000; bus.id_taken = 1;
    sbq.push_back(mkExp(32'h5000_0090, 32'h5000_1000, 2'b10));
    @(negedge clk);
    check("fq1_ready", 64'({bus.ex_ready, bus.id_ready}), 64'(2'b11));
    @(posedge clk); #1;
    bus.ex_pc = 32'h5000_00B0; bus.id_pc = 32'h5000_00C0;
    @(negedge clk);
    check("fq2_ready", 64'({bus.ex_ready, bus.id_ready}), 64'(2'b11));
    @(posedge clk); #1;
    bus.ex_valid = 0; bus.id_valid = 0; flush_req = 1;
    @(negedge clk);
    check("flush_wr_en", 64'(bus.wr_en), 64'd0);
    check("flush_readies", 64'({bus.ex_ready, bus.id_ready}), 64'd0);
    check("flush_pred_enable", 64'(pred_enable), 64'd1);
    check("flush_prior_write", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;
    flush_req = 0;
    sweepCheck("flush_sweep");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_flush_idle", 64'(bus.wr_en), 64'd0);
      @(posedge clk); #1;
    end

    // Refusals while flushing continuously: 4 + 2 per edge, capped at 255.
    flush_req = 1; bus.ex_valid = 1; bus.id_valid = 1;
    repeat (125) @(posedge clk);
    @(negedge clk);
    check("drop_254", 64'(drop_cnt), 64'd254);
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("drop_sat", 64'(drop_cnt), 64'd255);
    @(posedge clk); #1;
    flush_req = 0; bus.ex_valid = 0; bus.id_valid = 0;
    for (int i = 0; i < 40 && pred_enable !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("recover_pred_enable", 64'(pred_enable), 64'd1);
    check("drop_hold", 64'(drop_cnt), 64'd255);

    // Reset at sweep index 17 of a flush restarts the sweep from 0.
    flush_req = 1;
    @(posedge clk); #1;
    flush_req = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("pre_reset_sweep", 64'(bus.wr_index), 64'(i));
      if (i < 17) begin
        @(posedge clk); #1;
      end
    end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    sweepCheck("reset_sweep");
    check("drop_after_reset", 64'(drop_cnt), 64'd0);

    sbq.push_back(mkExp(32'h6000_0070, 32'h6000_0800, 2'b10));
    send(1, 32'h6000_0070, 32'h6000_0800, 1);
    drain(1, "final_update");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
